mirfak_hazard_unit: RTL and testbench

Parametrised pipeline hazard controller for Mirfak cores with configurable back-end depth (NFWD stages after ID, e.g. EX/MEM/WB).
- Priority forwarding-select generation for ID operands.
- Load-use and not-yet-ready stalls per stage.
- A 32-entry register scoreboard for long-latency writebacks (mult/div, non-blocking loads).
- A multi-cycle flush state machine on kill events.
- A stall-cycle performance counter.
- Per-pipeline-register enable/clear generation.

---
 rtl/mirfak_hazard_unit.sv | 150 +++++++++++++++
 tb/tb_mirfak_hazard_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mirfak_hazard_unit.sv
// Hazard controller for Mirfak cores: operand forwarding selects, stalls, a long-latency
// scoreboard, kill-driven flush sequencing and per-register enable/clear generation.
module mirfak_hazard_unit #(
    parameter int unsigned NFWD         = 2,
    parameter int unsigned ENABLE_SB    = 1,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned STALL_CNT_W  = 32,
    localparam int unsigned SELW        = $clog2(NFWD + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [4:0]             id_rs1_i,
    input  logic [4:0]             id_rs2_i,
    input  logic                   id_use_rs1_i,
    input  logic                   id_use_rs2_i,
    input  logic [5*NFWD-1:0]      stg_wa_i,
    input  logic [NFWD-1:0]        stg_wen_i,
    input  logic [NFWD-1:0]        stg_data_ok_i,
    input  logic [NFWD-1:0]        stg_busy_i,
    input  logic                   if_ready_i,
    input  logic                   sb_issue_i,
    input  logic [4:0]             sb_issue_wa_i,
    input  logic                   sb_done_i,
    input  logic [4:0]             sb_done_wa_i,
    input  logic                   kill_i,
    input  logic                   bj_taken_i,
    output logic [SELW-1:0]        id_fwd_a_sel_o,
    output logic [SELW-1:0]        id_fwd_b_sel_o,
    output logic [NFWD:0]          enable_o,
    output logic [NFWD:0]          clear_o,
    output logic                   flushing_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o
);

    typedef enum logic [0:0] {StRun, StFlush} state_e;

    state_e                 state_q, state_d;
    logic [3:0]             fcnt_q, fcnt_d;
    logic [31:0]            pend_q, pend_d, pend;
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    logic            haz_a, haz_b, sb_haz;
    logic [NFWD-1:0] r;
    logic            id_ready, if_ready;
    logic [NFWD+1:0] rv;
    logic            stall_inc;

    assign pend = (ENABLE_SB != 0) ? pend_q : 32'd0;

    // Walk from oldest to youngest so the youngest matching stage wins.
    always_comb begin
        id_fwd_a_sel_o = '0;
        id_fwd_b_sel_o = '0;
        haz_a          = 1'b0;
        haz_b          = 1'b0;
        for (int k = int'(NFWD) - 1; k >= 0; k--) begin
            if (id_use_rs1_i && id_rs1_i != 5'd0 && stg_wen_i[k] &&
                stg_wa_i[5*k +: 5] == id_rs1_i) begin
                id_fwd_a_sel_o = SELW'(k + 1);
                haz_a          = !stg_data_ok_i[k];
            end
            if (id_use_rs2_i && id_rs2_i != 5'd0 && stg_wen_i[k] &&
                stg_wa_i[5*k +: 5] == id_rs2_i) begin
                id_fwd_b_sel_o = SELW'(k + 1);
                haz_b          = !stg_data_ok_i[k];
            end
        end
    end

    assign sb_haz = (id_use_rs1_i && pend[id_rs1_i]) || (id_use_rs2_i && pend[id_rs2_i]);

    always_comb begin
        r[NFWD-1] = !stg_busy_i[NFWD-1];
        for (int k = int'(NFWD) - 2; k >= 0; k--) begin
            r[k] = r[k+1] && !stg_busy_i[k];
        end
    end

    assign id_ready = r[0] && !haz_a && !haz_b && !sb_haz;
    assign if_ready = id_ready && if_ready_i;

    always_comb begin
        rv    = '0;
        rv[0] = if_ready;
        rv[1] = id_ready;
        for (int j = 2; j <= int'(NFWD); j++) begin
            rv[j] = r[j-2];
        end
        rv[NFWD+1] = 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        fcnt_d     = fcnt_q;
        enable_o   = rv[NFWD:0];
        clear_o    = ~rv[NFWD:0] & rv[NFWD+1:1];
        clear_o[0] = clear_o[0] | bj_taken_i;
        flushing_o = (state_q == StFlush);
        if (kill_i) begin
            state_d = StFlush;
            fcnt_d  = 4'(FLUSH_CYCLES - 1);
        end else if (state_q == StFlush) begin
            if (fcnt_q == 4'd0) begin
                state_d = StRun;
            end else begin
                fcnt_d = fcnt_q - 4'd1;
            end
        end
        if (kill_i || state_q == StFlush) begin
            enable_o = '1;
            clear_o  = '1;
        end
    end

    // Done clears before issue sets, so a same-register issue/done leaves the bit pending.
    always_comb begin
        pend_d = pend_q;
        if (ENABLE_SB != 0) begin
            if (kill_i) begin
                pend_d = '0;
            end else begin
                if (sb_done_i) pend_d[sb_done_wa_i] = 1'b0;
                if (sb_issue_i && id_ready && state_q == StRun && sb_issue_wa_i != 5'd0) begin
                    pend_d[sb_issue_wa_i] = 1'b1;
                end
            end
        end else begin
            pend_d = '0;
        end
    end

    assign stall_inc = (state_q == StRun) && !kill_i && if_ready_i && !id_ready;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StRun;
            fcnt_q      <= 4'd0;
            pend_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            pend_q  <= pend_d;
            if (stall_inc) stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_mirfak_hazard_unit.sv
// Directed bench for mirfak_hazard_unit (NFWD=2, FLUSH_CYCLES=3): vector table plus
// hand-written scoreboard, flush and reset sequences.
module tb_mirfak_hazard_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2;
    logic        id_use_rs1, id_use_rs2;
    logic [9:0]  stg_wa;
    logic [1:0]  stg_wen, stg_data_ok, stg_busy;
    logic        if_ready_in;
    logic        sb_issue, sb_done;
    logic [4:0]  sb_issue_wa, sb_done_wa;
    logic        kill, bj_taken;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic [2:0]  enable, clear;
    logic        flushing;
    logic [31:0] stall_cnt;

    int total = 0;
    int bad   = 0;
    int exp_stall = 0;

    always #5 clk = ~clk;

    mirfak_hazard_unit #(
        .NFWD(2), .ENABLE_SB(1), .FLUSH_CYCLES(3), .STALL_CNT_W(32)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2),
        .stg_wa_i(stg_wa), .stg_wen_i(stg_wen), .stg_data_ok_i(stg_data_ok),
        .stg_busy_i(stg_busy), .if_ready_i(if_ready_in),
        .sb_issue_i(sb_issue), .sb_issue_wa_i(sb_issue_wa),
        .sb_done_i(sb_done), .sb_done_wa_i(sb_done_wa),
        .kill_i(kill), .bj_taken_i(bj_taken),
        .id_fwd_a_sel_o(fwd_a_sel), .id_fwd_b_sel_o(fwd_b_sel),
        .enable_o(enable), .clear_o(clear), .flushing_o(flushing),
        .stall_cnt_o(stall_cnt)
    );

    typedef struct {
        string      nm;
        logic [4:0] rs1, rs2;
        logic       u1, u2;
        logic [9:0] wa;
        logic [1:0] wen, ok, busy;
        logic       ifr, bj;
        logic [1:0] sa, sb;
        logic [2:0] en, clr;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Checks outputs mid-cycle, then books the stall the coming edge should count.
    task automatic step(input string nm, input logic [2:0] en, input logic [2:0] clr,
                        input logic fl);
        #1;
        check({nm, "_en"}, 32'(enable), 32'(en));
        check({nm, "_clr"}, 32'(clear), 32'(clr));
        check({nm, "_flush"}, 32'(flushing), 32'(fl));
        check({nm, "_stall"}, stall_cnt, exp_stall);
        if (if_ready_in && !en[1]) exp_stall++;
    endtask

    task automatic idle_inputs();
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        stg_wa = 0; stg_wen = 0; stg_data_ok = 2'b11; stg_busy = 0;
        if_ready_in = 1; sb_issue = 0; sb_issue_wa = 0; sb_done = 0; sb_done_wa = 0;
        kill = 0; bj_taken = 0;
    endtask

    initial begin
        vecs[0]  = '{"fwd_ex",    5, 0, 1, 0, {5'd5, 5'd5},   2'b11, 2'b11, 2'b00, 1, 0, 1, 0, 3'b111, 3'b000};
        vecs[1]  = '{"load_use",  3, 7, 1, 1, {5'd3, 5'd7},   2'b11, 2'b10, 2'b00, 1, 0, 2, 1, 3'b100, 3'b010};
        vecs[2]  = '{"load_ok",   3, 7, 1, 1, {5'd3, 5'd7},   2'b11, 2'b11, 2'b00, 1, 0, 2, 1, 3'b111, 3'b000};
        vecs[3]  = '{"busy1",     0, 0, 0, 0, 10'd0,          2'b00, 2'b11, 2'b10, 1, 0, 0, 0, 3'b000, 3'b100};
        vecs[4]  = '{"bj",        0, 0, 0, 0, 10'd0,          2'b00, 2'b11, 2'b00, 1, 1, 0, 0, 3'b111, 3'b001};
        vecs[5]  = '{"rs_zero",   0, 0, 1, 1, 10'd0,          2'b11, 2'b00, 2'b00, 1, 0, 0, 0, 3'b111, 3'b000};
        vecs[6]  = '{"no_use",    6, 0, 0, 0, {5'd6, 5'd6},   2'b11, 2'b00, 2'b00, 1, 0, 0, 0, 3'b111, 3'b000};
        vecs[7]  = '{"wen_off",   8, 0, 1, 0, {5'd8, 5'd8},   2'b10, 2'b01, 2'b00, 1, 0, 2, 0, 3'b100, 3'b010};
        vecs[8]  = '{"no_older",  0, 4, 0, 1, {5'd4, 5'd4},   2'b11, 2'b10, 2'b00, 1, 0, 0, 1, 3'b100, 3'b010};
        vecs[9]  = '{"if_idle",   0, 0, 0, 0, 10'd0,          2'b00, 2'b11, 2'b00, 0, 0, 0, 0, 3'b110, 3'b001};
        vecs[10] = '{"busy0",     0, 0, 0, 0, 10'd0,          2'b00, 2'b11, 2'b01, 1, 0, 0, 0, 3'b000, 3'b100};
        vecs[11] = '{"two_ops",  10, 11, 1, 1, {5'd11, 5'd10}, 2'b11, 2'b11, 2'b00, 1, 0, 1, 2, 3'b111, 3'b000};

        idle_inputs();
        if_ready_in = 0;
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        step("reset", 3'b110, 3'b001, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            idle_inputs();
            id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
            id_use_rs1 = vecs[i].u1; id_use_rs2 = vecs[i].u2;
            stg_wa = vecs[i].wa; stg_wen = vecs[i].wen; stg_data_ok = vecs[i].ok;
            stg_busy = vecs[i].busy; if_ready_in = vecs[i].ifr; bj_taken = vecs[i].bj;
            #1;
            check({vecs[i].nm, "_sel_a"}, 32'(fwd_a_sel), 32'(vecs[i].sa));
            check({vecs[i].nm, "_sel_b"}, 32'(fwd_b_sel), 32'(vecs[i].sb));
            #1;
            step(vecs[i].nm, vecs[i].en, vecs[i].clr, 0);
        end

        // Long-latency issue, dependent stall, done releases one cycle later.
        @(negedge clk); idle_inputs(); sb_issue = 1; sb_issue_wa = 9;
        step("sb_issue", 3'b111, 3'b000, 0);
        @(negedge clk); idle_inputs(); id_rs1 = 9; id_use_rs1 = 1;
        step("sb_wait", 3'b100, 3'b010, 0);
        @(negedge clk); sb_done = 1; sb_done_wa = 9;
        step("sb_done_cyc", 3'b100, 3'b010, 0);
        @(negedge clk); sb_done = 0;
        step("sb_released", 3'b111, 3'b000, 0);

        // Issue and done on the same register in one cycle keeps it pending.
        @(negedge clk); idle_inputs(); sb_issue = 1; sb_issue_wa = 9; sb_done = 1; sb_done_wa = 9;
        step("sb_same", 3'b111, 3'b000, 0);
        @(negedge clk); idle_inputs(); id_rs1 = 9; id_use_rs1 = 1;
        step("sb_same_pend", 3'b100, 3'b010, 0);
        @(negedge clk); sb_done = 1; sb_done_wa = 9;
        step("sb_same_done", 3'b100, 3'b010, 0);
        @(negedge clk); idle_inputs(); sb_issue = 1; sb_issue_wa = 0;
        step("sb_issue_r0", 3'b111, 3'b000, 0);
        @(negedge clk); idle_inputs(); id_rs1 = 0; id_use_rs1 = 1;
        step("sb_r0_clear", 3'b111, 3'b000, 0);

        // Kill: four cleared cycles, three flushing, scoreboard wiped.
        @(negedge clk); idle_inputs(); sb_issue = 1; sb_issue_wa = 9;
        step("pre_kill_issue", 3'b111, 3'b000, 0);
        @(negedge clk); idle_inputs(); id_rs1 = 9; id_use_rs1 = 1; kill = 1;
        step("kill", 3'b111, 3'b111, 0);
        @(negedge clk); kill = 0;
        step("flush1", 3'b111, 3'b111, 1);
        @(negedge clk);
        step("flush2", 3'b111, 3'b111, 1);
        @(negedge clk);
        step("flush3", 3'b111, 3'b111, 1);
        @(negedge clk);
        step("post_flush", 3'b111, 3'b000, 0);

        // Second kill inside FLUSH reloads the counter.
        @(negedge clk); idle_inputs(); kill = 1;
        step("kill_a", 3'b111, 3'b111, 0);
        @(negedge clk); kill = 0;
        step("reload_f1", 3'b111, 3'b111, 1);
        @(negedge clk); kill = 1;
        step("reload_kill", 3'b111, 3'b111, 1);
        @(negedge clk); kill = 0;
        step("reload_f2", 3'b111, 3'b111, 1);
        @(negedge clk);
        step("reload_f3", 3'b111, 3'b111, 1);
        @(negedge clk);
        step("reload_f4", 3'b111, 3'b111, 1);
        @(negedge clk);
        step("reload_run", 3'b111, 3'b000, 0);

        // Asynchronous reset in the middle of FLUSH.
        @(negedge clk); idle_inputs(); kill = 1;
        step("kill_b", 3'b111, 3'b111, 0);
        @(negedge clk); kill = 0;
        step("pre_rst_flush", 3'b111, 3'b111, 1);
        rst = 1;
        #1;
        check("rst_flushing", 32'(flushing), 0);
        check("rst_stall_cnt", stall_cnt, 0);
        exp_stall = 0;
        @(negedge clk); rst = 0;
        step("after_rst", 3'b111, 3'b000, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
